// File: rtl/alu_div_if.sv
// alu_div_if: operand, handshake and result bundle for the multi-cycle divider
`timescale 1ns/1ps
interface alu_div_if;
  logic start, Sign;
  logic [31:0] A, B;
  logic busy, done;
  logic [31:0] Q, R;
  logic Z, N, V, DZ;
  modport master (output start, Sign, A, B, input busy, done, Q, R, Z, N, V, DZ);
  modport slave (input start, Sign, A, B, output busy, done, Q, R, Z, N, V, DZ);
endinterface

// File: rtl/alu_div.sv
// alu_div: 32-bit restoring shift-and-subtract divider, signed or unsigned, 33-cycle latency
`timescale 1ns/1ps
module alu_div (
  input logic clk,
  input logic reset,
  alu_div_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_nx;
  logic [5:0] cnt;
  logic [31:0] dvd, dvs, rem, q_fix, r_fix, q_out;
  logic [32:0] rem_sh, diff;
  logic sgn, neg_q, neg_r, ovf, dz, accept;
  assign accept = state == IDLE && bus.start;
  // dvd shifts out dividend bits at the top and collects quotient bits at the bottom
  assign rem_sh = {rem, dvd[31]};
  assign diff = rem_sh - {1'b0, dvs};
  assign q_fix = neg_q ? -dvd : dvd;
  assign r_fix = neg_r ? -rem : rem;
  assign q_out = dz ? '1 : q_fix;
  always_comb begin
    state_nx = state;
    if (accept) state_nx = bus.B == '0 ? DONE : CALC;
    else if (state == CALC && cnt == 6'd31) state_nx = DONE;
    else if (state == DONE) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      rem <= '0;
      dvd <= '0;
      dvs <= '0;
      sgn <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      ovf <= 1'b0;
      dz <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.Q <= '0;
      bus.R <= '0;
      bus.Z <= 1'b1;
      bus.N <= 1'b0;
      bus.V <= 1'b0;
      bus.DZ <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      if (accept) begin
        sgn <= bus.Sign;
        // divide-by-zero keeps A raw so it can be returned as the remainder
        dvd <= (bus.Sign && bus.A[31] && bus.B != '0) ? -bus.A : bus.A;
        dvs <= (bus.Sign && bus.B[31]) ? -bus.B : bus.B;
        neg_q <= bus.Sign & (bus.A[31] ^ bus.B[31]);
        neg_r <= bus.Sign & bus.A[31];
        ovf <= bus.Sign && bus.A == 32'h8000_0000 && bus.B == '1;
        dz <= bus.B == '0;
        cnt <= '0;
        rem <= '0;
        bus.busy <= 1'b1;
      end else if (state == CALC) begin
        rem <= diff[32] ? rem_sh[31:0] : diff[31:0];
        dvd <= {dvd[30:0], ~diff[32]};
        cnt <= cnt + 6'd1;
      end else if (state == DONE) begin
        bus.busy <= 1'b0;
        bus.done <= 1'b1;
        bus.Q <= q_out;
        bus.R <= dz ? dvd : r_fix;
        bus.Z <= q_out == '0;
        bus.N <= sgn & q_out[31];
        bus.V <= ovf;
        bus.DZ <= dz;
      end
    end
  end
endmodule

// File: tb/tb_alu_div.sv
// tb_alu_div: directed and random checks of alu_div against an arithmetic reference model
`timescale 1ns/1ps
module tb_alu_div;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_checks = 0;
  int n_fails = 0;
  int cyc;
  bit seen;
  logic [31:0] eq, er;
  logic ez, en, ev, edz;
  alu_div_if bus();
  alu_div dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit s, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (b == 0) begin
      eq = '1; er = a; edz = 1; ev = 0;
    end else if (s) begin
      eq = 32'(sa / sb); er = 32'(sa % sb); edz = 0;
      ev = (sa == -64'sd2147483648) && (sb == -64'sd1);
    end else begin
      eq = a / b; er = a % b; edz = 0; ev = 0;
    end
    ez = (eq == 0);
    en = s & eq[31];
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".Q"}, bus.Q, eq);
    check({tag, ".R"}, bus.R, er);
    check({tag, ".Z"}, 32'(bus.Z), 32'(ez));
    check({tag, ".N"}, 32'(bus.N), 32'(en));
    check({tag, ".V"}, 32'(bus.V), 32'(ev));
    check({tag, ".DZ"}, 32'(bus.DZ), 32'(edz));
  endtask

  task automatic run(input string tag, input bit s, input logic [31:0] a, input logic [31:0] b);
    model(s, a, b);
    @(negedge clk);
    bus.start = 1; bus.Sign = s; bus.A = a; bus.B = b;
    @(posedge clk); #1;
    bus.start = 0; bus.Sign = 1'($urandom); bus.A = $urandom; bus.B = $urandom;
    check({tag, ".busy"}, 32'(bus.busy), 32'd1);
    cyc = 0;
    while (!bus.done && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, ".latency"}, cyc, (b == 0) ? 32'd1 : 32'd33);
    check({tag, ".busy_at_done"}, 32'(bus.busy), 32'd0);
    check_outputs(tag);
  endtask

  initial begin
    bus.start = 0; bus.Sign = 0; bus.A = '0; bus.B = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.busy", 32'(bus.busy), 32'd0);
    check("rst.done", 32'(bus.done), 32'd0);
    check("rst.Q", bus.Q, 32'd0);
    check("rst.R", bus.R, 32'd0);
    check("rst.Z", 32'(bus.Z), 32'd1);
    check("rst.NVDZ", {29'd0, bus.N, bus.V, bus.DZ}, 32'd0);
    @(negedge clk); reset = 1;

    run("unsigned", 0, 32'd100, 32'd7);
    check("unsigned.Q14", bus.Q, 32'd14);
    run("signed1", 1, 32'hFFFF_FFF9, 32'd2);
    check("signed1.Q", bus.Q, 32'hFFFF_FFFD);
    run("signed2", 1, 32'd7, 32'hFFFF_FFFE);
    check("signed2.R", bus.R, 32'd1);
    run("divzero", 1, 32'h1234_5678, 32'd0);
    run("overflow", 1, 32'h8000_0000, 32'hFFFF_FFFF);
    check("overflow.V", 32'(bus.V), 32'd1);
    run("ubig", 0, 32'h8000_0000, 32'hFFFF_FFFF);
    run("divzero_u", 0, 32'hDEAD_BEEF, 32'd0);

    repeat (5) @(posedge clk);
    #1;
    check("hold.Q", bus.Q, eq);
    check("hold.R", bus.R, er);

    // start while busy must be ignored
    model(0, 32'd50, 32'd5);
    @(negedge clk);
    bus.start = 1; bus.Sign = 0; bus.A = 32'd50; bus.B = 32'd5;
    @(posedge clk); #1;
    bus.start = 0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    bus.start = 1; bus.A = 32'd9; bus.B = 32'd3;
    @(posedge clk); #1;
    bus.start = 0; bus.A = 32'd77; bus.B = 32'd1;
    cyc = 10;
    while (!bus.done && cyc < 50) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("hs.latency", cyc, 32'd33);
    check_outputs("hs");
    run("hs2", 0, 32'd9, 32'd3);

    // reset in the middle of a division
    @(negedge clk);
    bus.start = 1; bus.Sign = 0; bus.A = 32'd1000; bus.B = 32'd7;
    @(posedge clk); #1;
    bus.start = 0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    reset = 0;
    #1;
    check("mid_rst.busy", 32'(bus.busy), 32'd0);
    check("mid_rst.done", 32'(bus.done), 32'd0);
    check("mid_rst.Q", bus.Q, 32'd0);
    check("mid_rst.R", bus.R, 32'd0);
    check("mid_rst.Z", 32'(bus.Z), 32'd1);
    @(negedge clk); reset = 1;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done) seen = 1;
    end
    check("mid_rst.no_done", 32'(seen), 32'd0);
    run("post_rst", 0, 32'd1000, 32'd10);

    for (int i = 0; i < 24; i++) begin
      logic [31:0] ra, rb;
      bit rs;
      ra = $urandom;
      rs = 1'($urandom);
      case ($urandom_range(0, 3))
        0: rb = 32'($urandom_range(1, 20));
        1: rb = (i % 6 == 0) ? 32'd0 : $urandom;
        2: rb = -32'($urandom_range(1, 20));
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      run("random", rs, ra, rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alu_div.md
# alu_div

Multi-cycle 32-bit integer divider that completes the ALU's arithmetic set. The combinational add/sub path handles addition and subtraction. This block handles the inverse of multiplication by repeated shift-and-subtract. It sits beside the ALU in the execute stage. It takes operands and a `Sign` mode bit with the same meaning as the ALU's, and returns quotient, remainder and ALU-style flags after a fixed 33-cycle latency. The pipeline stalls on `busy`.

## Interface
- No parameters; width fixed at 32.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `Sign`  in  1  1 = signed two's-complement, 0 = unsigned.
- `A`  in  32  dividend, captured with `start`.
- `B`  in  32  divisor, captured with `start`.
- `busy`  out  1  operation in progress.
- `done`  out  1  one-cycle pulse; `Q`, `R` and flags are valid from this cycle on.
- `Q`  out  32  quotient, held until the next accepted `start`.
- `R`  out  32  remainder, held until the next accepted `start`.
- `Z`  out  1  `Q`==0.
- `N`  out  1  `Sign` & `Q[31]`; always 0 when unsigned.
- `V`  out  1  signed overflow: `Sign` & A==0x80000000 & B==0xFFFFFFFF.
- `DZ`  out  1  divide by zero: B==0.

## Operation
- FSM states: IDLE, CALC, DONE.
- **IDLE**
  - `start`=1 captures A, B and Sign.
  - Stores |A| and |B| in signed mode, or raw values in unsigned mode.
  - Stores sign of Q = A[31]^B[31] and sign of R = A[31] (signed mode only).
  - Clears the 6-bit iteration counter and the 33-bit partial remainder.
  - Goes to CALC. If B==0, goes directly to DONE.
- **CALC**, one quotient bit per cycle, MSB first:
  - Shift the partial remainder left 1 and bring in the next dividend bit.
  - Trial-subtract the divisor with a 33-bit subtract.
  - If the result is non-negative, keep it and set the quotient bit to 1. Otherwise restore and set it to 0.
  - Counter 0..31; after the iteration with counter 31, go to DONE.
- **DONE**, one cycle:
  - Writes `Q`, `R`, `Z`, `N`, `V` and `DZ` and pulses `done`.
  - Signed corrections: Q is negated if its stored sign is 1; R is negated if A was negative. This gives truncation toward zero, so R takes the sign of the dividend.
  - Returns to IDLE.
- **Divide by zero:** Q=0xFFFFFFFF, R=A unmodified, DZ=1. Z and N are computed from that Q. V=0.
- **Signed overflow** (0x80000000 / -1): the normal datapath yields Q=0x80000000, R=0. V=1 and N=1.
- **Magnitudes:** |0x80000000| = 0x80000000 is treated as unsigned. The internal magnitude path is 32-bit unsigned plus one guard bit, so no special case is needed.
- **`start` while `busy`=1:** ignored; operands are not re-captured.
- **`start` in the DONE cycle:** ignored. It is accepted from the following cycle, in IDLE.
- **Outputs between operations:** `Q`, `R` and the flags hold their last values through IDLE. They update only in DONE.

## Timing
- Let E0 be the clock edge that samples `start`=1 in IDLE.
- **Normal case**
  - `busy`=1 after E0 through E33.
  - CALC covers E1..E32.
  - The state enters DONE at E32. `done`=1, with valid results, in the cycle following E33.
  - Latency is 33 cycles from `start` to `done`.
  - Back-to-back throughput: one division per 34 cycles.
- **Divide by zero:** `done` is high in the cycle after E1 (latency 1); `busy` is high for 1 cycle.
- **`busy`:** registered; it deasserts in the same cycle that `done` is high.
- **Reset**
  - Asynchronous active-low `reset` forces IDLE at any time, including mid-CALC. The in-flight operation is discarded.
  - Reset values: `busy`=0, `done`=0, `Q`=0, `R`=0, `Z`=1, `N`=0, `V`=0, `DZ`=0, counter 0.
- Operands need only be stable at E0. Later changes to A, B or Sign have no effect.

## Test plan
- **Unsigned:** Sign=0, A=100, B=7, start 1 cycle -> done exactly 33 cycles after the start edge; Q=14, R=2, Z=0, N=0, V=0, DZ=0.
- **Signed:** Sign=1, A=-7 (0xFFFFFFF9), B=2 -> Q=0xFFFFFFFD (-3), R=0xFFFFFFFF (-1), N=1. Then A=7, B=-2 -> Q=-3, R=1.
- **Divide by zero:** Sign=1, A=0x12345678, B=0 -> done 1 cycle after start; Q=0xFFFFFFFF, R=0x12345678, DZ=1, N=1, V=0.
- **Overflow and unsigned large values**
  - Sign=1, A=0x80000000, B=0xFFFFFFFF -> Q=0x80000000, R=0, V=1, N=1.
  - Same operands with Sign=0 -> Q=0, R=0x80000000, Z=1, V=0.
- **Handshake:** start A=50, B=5. At cycle 10, pulse start with A=9, B=3 and change A/B -> that start is ignored; done at cycle 33 with Q=10, R=0. Then start again -> accepted; Q=3.
- **Reset mid-operation:** assert reset at cycle 15 of a division -> busy=0, done never pulses, Q=0, R=0, Z=1 immediately. After release, start 1000/10 -> Q=100, R=0 after 33 cycles.
